// File: rtl/psw_unit.sv
// psw_unit: registered XM23 processor status word with ALU flag derivation,
// SETCC/CLRCC, direct writes and an exception PSW shadow stack.
// Bit map: C=0 Z=1 N=2 SLP=3 V=4 CPRI=7:5 FLT=8 PPRI=15:13, bits 12:9 always 0.
module psw_unit #(
    parameter int          WIDTH        = 16,
    parameter int          SHADOW_DEPTH = 4,
    parameter logic [15:0] RESET_PSW    = 16'h00E0
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             alu_valid_i,
    input  logic             alu_byte_i,
    input  logic [WIDTH-1:0] alu_a_i,
    input  logic [WIDTH-1:0] alu_b_i,
    input  logic [WIDTH-1:0] alu_result_i,
    input  logic [3:0]       alu_flag_msk_i,
    input  logic             cc_valid_i,
    input  logic             cc_set_i,
    input  logic [3:0]       cc_bits_i,
    input  logic             wr_valid_i,
    input  logic [15:0]      wr_data_i,
    input  logic             exc_enter_i,
    input  logic [2:0]       exc_pri_i,
    input  logic             exc_return_i,
    output logic [15:0]      psw_o,
    output logic [15:0]      psw_fwd_o,
    output logic             stack_empty_o,
    output logic             stack_full_o
);

    localparam int          CW       = $clog2(SHADOW_DEPTH + 1);
    localparam int          IW       = (SHADOW_DEPTH > 1) ? $clog2(SHADOW_DEPTH) : 1;
    localparam logic [15:0] WR_MASK  = 16'hE1FF;
    localparam logic [15:0] FLT_BIT  = 16'h0100;

    // Flags {V,N,Z,C} from the sign bits of operands and result at bit m.
    function automatic logic [3:0] alu_flags(input logic [WIDTH-1:0] a,
                                             input logic [WIDTH-1:0] b,
                                             input logic [WIDTH-1:0] r,
                                             input logic             byte_mode);
        logic am;
        logic bm;
        logic rm;
        logic z;
        if (byte_mode) begin
            am = a[7];
            bm = b[7];
            rm = r[7];
            z  = (r[7:0] == 8'h00);
        end else begin
            am = a[WIDTH-1];
            bm = b[WIDTH-1];
            rm = r[WIDTH-1];
            z  = (r == {WIDTH{1'b0}});
        end
        alu_flags[3] = (~bm & ~am & rm) | (bm & am & ~rm);
        alu_flags[2] = rm;
        alu_flags[1] = z;
        alu_flags[0] = (bm & am) | ((bm | am) & ~rm);
    endfunction

    // Replace the selected {V,N,Z,C} bits of p with val; everything else holds.
    function automatic logic [15:0] merge_flags(input logic [15:0] p,
                                                input logic [3:0]  sel,
                                                input logic [3:0]  val);
        logic [15:0] q;
        q = p;
        if (sel[0]) q[0] = val[0];
        if (sel[1]) q[1] = val[1];
        if (sel[2]) q[2] = val[2];
        if (sel[3]) q[4] = val[3];
        return q;
    endfunction

    logic [15:0]   psw_q;
    logic [15:0]   psw_d;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          empty_q;
    logic          full_q;
    logic [15:0]   stack_q [SHADOW_DEPTH];
    logic          push_s;
    logic [CW-1:0] top_s;
    logic [IW-1:0] top_idx_s;
    logic [IW-1:0] push_idx_s;
    logic [15:0]   pop_val_s;

    assign top_s      = cnt_q - CW'(1);
    assign top_idx_s  = top_s[IW-1:0];
    assign push_idx_s = cnt_q[IW-1:0];
    assign pop_val_s  = stack_q[top_idx_s];

    // Next-PSW and stack count: one prioritised action per cycle.
    always_comb begin
        psw_d  = psw_q;
        cnt_d  = cnt_q;
        push_s = 1'b0;
        if (exc_enter_i) begin
            if (!full_q) begin
                push_s = 1'b1;
                cnt_d  = cnt_q + CW'(1);
                psw_d  = {psw_q[7:5], 4'h0, psw_q[8], exc_pri_i, 5'b00000};
            end else begin
                psw_d = psw_q | FLT_BIT;
            end
        end else if (exc_return_i) begin
            if (!empty_q) begin
                cnt_d = top_s;
                psw_d = pop_val_s | (psw_q & FLT_BIT);
            end else begin
                psw_d = psw_q | FLT_BIT;
            end
        end else if (wr_valid_i) begin
            psw_d = wr_data_i;
        end else if (cc_valid_i) begin
            psw_d = merge_flags(psw_q, cc_bits_i, {4{cc_set_i}});
        end else if (alu_valid_i) begin
            psw_d = merge_flags(psw_q, alu_flag_msk_i,
                                alu_flags(alu_a_i, alu_b_i, alu_result_i, alu_byte_i));
        end else begin
            psw_d = psw_q;
        end
        psw_d = psw_d & WR_MASK;
    end

    // PSW, occupancy count and registered stack status.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            psw_q   <= RESET_PSW;
            cnt_q   <= {CW{1'b0}};
            empty_q <= 1'b1;
            full_q  <= 1'b0;
        end else begin
            psw_q   <= psw_d;
            cnt_q   <= cnt_d;
            empty_q <= (cnt_d == {CW{1'b0}});
            full_q  <= (cnt_d == CW'(SHADOW_DEPTH));
        end
    end

    // Shadow stack storage; contents are only meaningful below the count.
    always_ff @(posedge clk_i) begin
        if (push_s && !rst_i) begin
            stack_q[push_idx_s] <= psw_q;
        end
    end

    assign psw_o         = psw_q;
    assign psw_fwd_o     = rst_i ? RESET_PSW : psw_d;
    assign stack_empty_o = empty_q;
    assign stack_full_o  = full_q;

endmodule
